// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and RV32 size codes for the unified-memory port arbiter.
package riscv_mem_pkg;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating streak counter: counts DM wins while IF waits, flags when IF must win.
module starve_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == CW'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and DM requesters onto one single-ported memory, one transaction at a time.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  input  logic              if_flush,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_funct3,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              flush_q, flush_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic if_gnt_c, dm_gnt_c;
  logic st_inc, st_clr, st_at_limit;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (st_inc),
    .clr_i      (st_clr),
    .at_limit_o (st_at_limit)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    flush_d   = flush_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_gnt_c  = 1'b0;
    dm_gnt_c  = 1'b0;
    st_inc    = 1'b0;
    st_clr    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (dm_req && !(if_req && st_at_limit)) begin
          owner_d  = OWN_DM;
          dm_gnt_c = 1'b1;
          we_d     = dm_we;
          f3_d     = dm_funct3;
          addr_d   = dm_addr;
          wdata_d  = dm_wdata;
          st_inc   = if_req;
          st_clr   = !if_req;
          flush_d  = 1'b0;
          state_d  = ARB_ISSUE;
        end else if (if_req) begin
          owner_d  = OWN_IF;
          if_gnt_c = 1'b1;
          we_d     = 1'b0;
          f3_d     = F3_LW;
          addr_d   = if_addr;
          wdata_d  = '0;
          st_clr   = 1'b1;
          flush_d  = 1'b0;
          state_d  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (if_flush && owner_q == OWN_IF) flush_d = 1'b1;
        if (mem_gnt) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (if_flush && owner_q == OWN_IF) flush_d = 1'b1;
        if (mem_rvalid) begin
          // A flush arriving with the response still kills it, hence the live if_flush term.
          if (owner_q == OWN_IF) if_rvalid = !flush_q && !if_flush;
          else                   dm_rvalid = 1'b1;
          flush_d = 1'b0;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grants are combinational from the requests, so they are masked while reset is held.
  assign if_gnt     = if_gnt_c & reset;
  assign dm_gnt     = dm_gnt_c & reset;
  assign mem_req    = (state_q == ARB_ISSUE);
  assign mem_we     = we_q;
  assign mem_funct3 = f3_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign if_rdata   = mem_rdata;
  assign dm_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      flush_q <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      flush_q <= flush_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [2:0]    dm_funct3 = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_funct3;

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_flush   (if_flush),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_funct3  (dm_funct3),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: one pending transaction record plus the DM-streak count.
  bit            m_busy, m_dm, m_acc, m_flush;
  int unsigned   m_streak;
  logic          m_we;
  logic [2:0]    m_f3;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            last_eg_if, last_eg_dm;

  logic          obs_if_gnt, obs_dm_gnt, obs_if_rvalid, obs_dm_rvalid;
  logic [DW-1:0] obs_if_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_dm = 0; m_acc = 0; m_flush = 0; m_streak = 0;
    m_we = 1'b0; m_f3 = '0; m_addr = '0; m_wdata = '0;
    last_eg_if = 0; last_eg_dm = 0;
  endtask

  // Called just after a rising edge: checks outputs mid-cycle, then advances the model at the edge.
  task automatic step();
    bit win_dm, eg_if, eg_dm, e_req, e_ifv, e_dmv;
    @(negedge clk);
    win_dm = dm_req && !(if_req && m_streak == LIMIT);
    eg_dm  = !m_busy && win_dm;
    eg_if  = !m_busy && if_req && !win_dm;
    e_req  = m_busy && !m_acc;
    e_dmv  = m_busy && m_acc && mem_rvalid && m_dm;
    e_ifv  = m_busy && m_acc && mem_rvalid && !m_dm && !m_flush && !if_flush;
    obs_if_gnt = if_gnt; obs_dm_gnt = dm_gnt;
    obs_if_rvalid = if_rvalid; obs_dm_rvalid = dm_rvalid; obs_if_rdata = if_rdata;
    chk("if_gnt", 64'(if_gnt), 64'(eg_if));
    chk("dm_gnt", 64'(dm_gnt), 64'(eg_dm));
    chk("mem_req", 64'(mem_req), 64'(e_req));
    chk("if_rvalid", 64'(if_rvalid), 64'(e_ifv));
    chk("dm_rvalid", 64'(dm_rvalid), 64'(e_dmv));
    if (e_req) begin
      chk("mem_we", 64'(mem_we), 64'(m_we));
      chk("mem_funct3", 64'(mem_funct3), 64'(m_f3));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    if (e_ifv) chk("if_rdata", 64'(if_rdata), 64'(mem_rdata));
    if (e_dmv) chk("dm_rdata", 64'(dm_rdata), 64'(mem_rdata));
    @(posedge clk);
    last_eg_if = eg_if; last_eg_dm = eg_dm;
    if (eg_dm || eg_if) begin
      m_busy = 1; m_acc = 0; m_flush = 0; m_dm = eg_dm;
      if (eg_dm) begin
        m_we = dm_we; m_f3 = dm_funct3; m_addr = dm_addr; m_wdata = dm_wdata;
        m_streak = if_req ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
      end else begin
        m_we = 1'b0; m_f3 = 3'b010; m_addr = if_addr; m_wdata = '0;
        m_streak = 0;
      end
    end else if (m_busy) begin
      if (!m_dm && if_flush) m_flush = 1;
      if (!m_acc) begin
        if (mem_gnt) m_acc = 1;
      end else if (mem_rvalid) begin
        m_busy = 0;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_if_gnt", 64'(if_gnt), 64'(0));
    chk("rst_dm_gnt", 64'(dm_gnt), 64'(0));
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_funct3", 64'(mem_funct3), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_if_rvalid", 64'(if_rvalid), 64'(0));
    chk("rst_dm_rvalid", 64'(dm_rvalid), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic serve(input int unsigned gwait, input int unsigned rwait, input logic [DW-1:0] data);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    repeat (gwait) step();
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    repeat (rwait) step();
    mem_rvalid = 1'b1; mem_rdata = data; step(); mem_rvalid = 1'b0;
  endtask

  function automatic logic [2:0] rand_f3(input logic we);
    logic [2:0] ld [5];
    ld = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    return we ? 3'($urandom_range(2, 0)) : ld[$urandom_range(4, 0)];
  endfunction

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // 1: IF-only fetch
    if_req = 1'b1; if_addr = 32'h10;
    step();
    chk("t1_if_gnt", 64'(obs_if_gnt), 64'(1));
    if_req = 1'b0;
    chk("t1_mem_req_next", 64'(mem_req), 64'(1));
    chk("t1_mem_addr", 64'(mem_addr), 64'h10);
    serve(0, 1, 32'h0050_0093);
    chk("t1_if_rvalid", 64'(obs_if_rvalid), 64'(1));
    chk("t1_if_rdata", 64'(obs_if_rdata), 64'h0050_0093);

    // 2: simultaneous requests, DM store wins
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b1; dm_funct3 = 3'b010; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    step();
    chk("t2_dm_first", 64'({obs_dm_gnt, obs_if_gnt}), 64'(2'b10));
    dm_req = 1'b0;
    chk("t2_mem_we", 64'(mem_we), 64'(1));
    chk("t2_mem_funct3", 64'(mem_funct3), 64'(3'b010));
    chk("t2_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    serve(1, 0, 32'h0);
    chk("t2_dm_ack", 64'(obs_dm_rvalid), 64'(1));
    step();
    chk("t2_if_next", 64'(obs_if_gnt), 64'(1));
    if_req = 1'b0;
    serve(0, 0, 32'h1111_2222);

    // 3: starvation limit
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b010; dm_addr = 32'h200; dm_wdata = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t3_grant%0d", i), 64'({obs_dm_gnt, obs_if_gnt}), (i == 4) ? 64'(2'b01) : 64'(2'b10));
      serve(0, 0, 32'(i));
    end
    dm_req = 1'b0; if_req = 1'b0;
    step();

    // 4: flush of an IF response, then a clean fetch; flush under DM ownership is ignored
    if_req = 1'b1; if_addr = 32'h80;
    step();
    if_req = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; if_flush = 1'b1;
    step();
    if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    step();
    chk("t4_flushed", 64'(obs_if_rvalid), 64'(0));
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h84;
    step();
    chk("t4_next_gnt", 64'(obs_if_gnt), 64'(1));
    if_req = 1'b0;
    serve(0, 0, 32'h5678);
    chk("t4_next_rvalid", 64'(obs_if_rvalid), 64'(1));
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h88;
    step();
    dm_req = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; if_flush = 1'b1; mem_rvalid = 1'b1;
    step();
    chk("t4_dm_unflushed", 64'(obs_dm_rvalid), 64'(1));
    if_flush = 1'b0; mem_rvalid = 1'b0;

    // 5: reset while issuing, stale response afterwards
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'hCAFE_F00D;
    step();
    dm_req = 1'b0; if_req = 1'b1;
    chk("t5_issuing", 64'(mem_req), 64'(1));
    apply_reset();
    if_req = 1'b0; mem_rvalid = 1'b1;
    repeat (2) begin
      step();
      chk("t5_stale", 64'({obs_if_rvalid, obs_dm_rvalid}), 64'(0));
    end
    mem_rvalid = 1'b0;

    // 6: memory withholds mem_gnt for 5 cycles
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b101; dm_addr = 32'h400;
    step();
    dm_addr = 32'h404; if_req = 1'b1; if_addr = 32'h48;
    repeat (5) begin
      step();
      chk("t6_no_gnt", 64'({obs_dm_gnt, obs_if_gnt}), 64'(0));
      chk("t6_addr", 64'(mem_addr), 64'h400);
      chk("t6_f3", 64'(mem_funct3), 64'(3'b101));
    end
    serve(0, 0, 32'hABCD);
    dm_req = 1'b0; if_req = 1'b0;
    step();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (last_eg_if || !if_req) begin
        if_req  = ($urandom % 2) == 1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom % 16 == 0) begin
        if_req = 1'b0;
      end
      if (last_eg_dm || !dm_req) begin
        dm_req    = ($urandom % 2) == 1;
        dm_we     = ($urandom % 2) == 1;
        dm_funct3 = rand_f3(dm_we);
        dm_addr   = $urandom;
        dm_wdata  = $urandom;
      end else if ($urandom % 16 == 0) begin
        dm_req = 1'b0;
      end
      if_flush   = ($urandom % 5) == 0;
      mem_gnt    = m_busy && !m_acc && ($urandom % 3 == 0);
      mem_rvalid = ($urandom % 3) == 0;
      mem_rdata  = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
